// File: rtl/led_sequencer_ctrl_if.sv
// Bundles the control and display signals of the LED sequencer.
//   run   : level, 1 = sequencer enabled, 0 = return to idle
//   hold  : level, 1 while running = freeze pattern and prescaler
//   mode  : 2-bit pattern select, latched when leaving idle
//   LED1..LED8 : pattern bits 0..7
//   tick  : one-cycle pulse after each pattern step
//   busy  : high while running or paused
// master drives the controls; slave is the sequencer itself.
interface led_sequencer_ctrl_if;
  logic       run;
  logic       hold;
  logic [1:0] mode;
  logic       LED1, LED2, LED3, LED4, LED5, LED6, LED7, LED8;
  logic       tick;
  logic       busy;

  modport master (
    output run, hold, mode,
    input  LED1, LED2, LED3, LED4, LED5, LED6, LED7, LED8, tick, busy
  );

  modport slave (
    input  run, hold, mode,
    output LED1, LED2, LED3, LED4, LED5, LED6, LED7, LED8, tick, busy
  );
endinterface

// File: rtl/led_sequencer_ctrl.sv
// Timed LED pattern sequencer. A 32-bit prescaler produces a step every DIV
// cycles of RUN time; each step advances an 8-bit pattern in one of four
// modes (chase, bounce, binary count, blink).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of led_sequencer_ctrl_if (run/hold/mode in,
//           LED1..LED8/tick/busy out, all outputs registered)
module led_sequencer_ctrl #(
  parameter int unsigned DIV = 32'd25000000
) (
  input logic                  clk,
  input logic                  rst_n,
  led_sequencer_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [31:0] DIV_M1 = 32'(DIV - 32'd1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  pat_q, pat_d;
  logic        dir_q, dir_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  led_q, led_d;
  logic        tick_q, tick_d;
  logic        busy_q, busy_d;

  logic [7:0]  nxt_s;
  logic        turn_s;
  logic [7:0]  seed_s;

  // Starting pattern for a mode: chase and bounce begin with one lit LED.
  function automatic logic [7:0] seed_of(input logic [1:0] m);
    logic [7:0] s;
    case (m)
      2'd0:    s = 8'h01;
      2'd1:    s = 8'h01;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Next pattern for the latched mode; bounce turns around at either end.
  always_comb begin
    nxt_s  = pat_q;
    turn_s = 1'b0;
    case (mode_q)
      2'd0: nxt_s = {pat_q[6:0], pat_q[7]};
      2'd1: begin
        if (dir_q) begin
          nxt_s = {1'b0, pat_q[7:1]};
        end else begin
          nxt_s = {pat_q[6:0], 1'b0};
        end
        turn_s = (nxt_s == 8'h80) || (nxt_s == 8'h01);
      end
      2'd2: nxt_s = pat_q + 8'd1;
      2'd3: nxt_s = ~pat_q;
      default: nxt_s = pat_q;
    endcase
  end

  assign seed_s = seed_of(bus.mode);

  // Next-state and datapath: run has priority over hold. An edge that
  // leaves PAUSE already counts as RUN time, so a hold of N cycles
  // stretches its interval by exactly N.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    led_d   = led_q;
    tick_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) begin
          state_d = bus.hold ? ST_PAUSE : ST_RUN;
          mode_d  = bus.mode;
          pat_d   = seed_s;
          led_d   = seed_s;
          cnt_d   = 32'd0;
          dir_d   = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 32'd0;
          pat_d   = 8'h00;
          dir_d   = 1'b0;
          led_d   = 8'h00;
          busy_d  = 1'b0;
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (!bus.run) begin
          state_d = ST_IDLE;
          cnt_d   = 32'd0;
          pat_d   = 8'h00;
          dir_d   = 1'b0;
          led_d   = 8'h00;
          busy_d  = 1'b0;
        end else if (bus.hold) begin
          state_d = ST_PAUSE;
          led_d   = pat_q;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          if (cnt_q == DIV_M1) begin
            cnt_d  = 32'd0;
            pat_d  = nxt_s;
            led_d  = nxt_s;
            tick_d = 1'b1;
            if (turn_s) begin
              dir_d = ~dir_q;
            end else begin
              dir_d = dir_q;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
            led_d = pat_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 32'd0;
        pat_d   = 8'h00;
        dir_d   = 1'b0;
        led_d   = 8'h00;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, pattern and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 32'd0;
      pat_q   <= 8'h00;
      dir_q   <= 1'b0;
      mode_q  <= 2'd0;
      led_q   <= 8'h00;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.LED1 = led_q[0];
  assign bus.LED2 = led_q[1];
  assign bus.LED3 = led_q[2];
  assign bus.LED4 = led_q[3];
  assign bus.LED5 = led_q[4];
  assign bus.LED6 = led_q[5];
  assign bus.LED7 = led_q[6];
  assign bus.LED8 = led_q[7];
  assign bus.tick = tick_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_led_sequencer_ctrl.sv
// Bench for led_sequencer_ctrl: three instances (DIV=4, 1, 2) share one
// stimulus stream; a pattern-index model is compared every cycle and
// directed literal checks pin key points.
module tb_led_sequencer_ctrl;

  logic       clk;
  logic       rst_n;
  logic       run_s;
  logic       hold_s;
  logic [1:0] mode_s;

  int checks;
  int failures;

  led_sequencer_ctrl_if if0 ();
  led_sequencer_ctrl_if if1 ();
  led_sequencer_ctrl_if if2 ();

  assign if0.run = run_s;  assign if0.hold = hold_s;  assign if0.mode = mode_s;
  assign if1.run = run_s;  assign if1.hold = hold_s;  assign if1.mode = mode_s;
  assign if2.run = run_s;  assign if2.hold = hold_s;  assign if2.mode = mode_s;

  led_sequencer_ctrl #(.DIV(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  led_sequencer_ctrl #(.DIV(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  led_sequencer_ctrl #(.DIV(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic [7:0] d_led  [3];
  logic       d_tick [3];
  logic       d_busy [3];

  assign d_led[0]  = {if0.LED8, if0.LED7, if0.LED6, if0.LED5, if0.LED4, if0.LED3, if0.LED2, if0.LED1};
  assign d_led[1]  = {if1.LED8, if1.LED7, if1.LED6, if1.LED5, if1.LED4, if1.LED3, if1.LED2, if1.LED1};
  assign d_led[2]  = {if2.LED8, if2.LED7, if2.LED6, if2.LED5, if2.LED4, if2.LED3, if2.LED2, if2.LED1};
  assign d_tick[0] = if0.tick;
  assign d_tick[1] = if1.tick;
  assign d_tick[2] = if2.tick;
  assign d_busy[0] = if0.busy;
  assign d_busy[1] = if1.busy;
  assign d_busy[2] = if2.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 2);
  endfunction

  // Pattern after k steps from the seed of mode m.
  function automatic logic [7:0] pat_of(input logic [1:0] m, input int k);
    int p;
    logic [7:0] one;
    one = 8'h01;
    case (m)
      2'd0: return one << (k % 8);
      2'd1: begin
        p = k % 14;
        if (p > 7) p = 14 - p;
        return one << p;
      end
      2'd2: return 8'(k % 256);
      default: return (k % 2 == 1) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // Model: active edge count since entering the running states.
  int         m_act  [3];
  logic [1:0] m_mode [3];
  logic [7:0] m_led  [3];
  logic       m_tick [3];
  logic       m_busy [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_act[i] <= 0; m_mode[i] <= 2'd0; m_led[i] <= 8'h00;
        m_tick[i] <= 1'b0; m_busy[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!run_s) begin
          m_busy[i] <= 1'b0; m_led[i] <= 8'h00; m_tick[i] <= 1'b0; m_act[i] <= 0;
        end else if (!m_busy[i]) begin
          m_busy[i] <= 1'b1; m_mode[i] <= mode_s; m_act[i] <= 0;
          m_led[i] <= pat_of(mode_s, 0); m_tick[i] <= 1'b0;
        end else if (hold_s) begin
          m_tick[i] <= 1'b0;
        end else begin
          m_act[i] <= m_act[i] + 1;
          if ((m_act[i] + 1) % div_of(i) == 0) begin
            m_tick[i] <= 1'b1;
            m_led[i]  <= pat_of(m_mode[i], (m_act[i] + 1) / div_of(i));
          end else begin
            m_tick[i] <= 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_led", i),  32'(d_led[i]),  32'(m_led[i]));
      chk($sformatf("u%0d_tick", i), 32'(d_tick[i]), 32'(m_tick[i]));
      chk($sformatf("u%0d_busy", i), 32'(d_busy[i]), 32'(m_busy[i]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; run_s = 1'b0; hold_s = 1'b0; mode_s = 2'd0;
    step(2);
    chk("rst_led", 32'(d_led[0]), 32'h00);
    chk("rst_busy", 32'(d_busy[0]), 32'h0);
    chk("rst_tick", 32'(d_tick[0]), 32'h0);
    rst_n = 1'b1;
    step(2);

    // chase
    run_s = 1'b1;
    step(1);  chk("chase_seed", 32'(d_led[0]), 32'h01);
              chk("chase_busy", 32'(d_busy[0]), 32'h1);
    step(3);  chk("chase_pre", 32'(d_led[0]), 32'h01);
              chk("chase_pre_tick", 32'(d_tick[0]), 32'h0);
    step(1);  chk("chase_s1", 32'(d_led[0]), 32'h02);
              chk("chase_s1_tick", 32'(d_tick[0]), 32'h1);
    step(1);  chk("chase_tick_1cyc", 32'(d_tick[0]), 32'h0);
    step(27); chk("chase_wrap", 32'(d_led[0]), 32'h01);
              chk("chase_wrap_tick", 32'(d_tick[0]), 32'h1);
    run_s = 1'b0;
    step(1);  chk("idle_led", 32'(d_led[0]), 32'h00);
              chk("idle_busy", 32'(d_busy[0]), 32'h0);

    // bounce
    mode_s = 2'd1; run_s = 1'b1;
    step(1);  chk("bnc_seed", 32'(d_led[0]), 32'h01);
    step(28); chk("bnc_top", 32'(d_led[0]), 32'h80);
    step(4);  chk("bnc_down", 32'(d_led[0]), 32'h40);
    step(24); chk("bnc_bottom", 32'(d_led[0]), 32'h01);
    step(4);  chk("bnc_up", 32'(d_led[0]), 32'h02);

    // mode change while running is ignored
    mode_s = 2'd3;
    step(4);  chk("mode_ignored", 32'(d_led[0]), 32'h04);
    run_s = 1'b0;
    step(1);  chk("drop_busy", 32'(d_busy[0]), 32'h0);
    run_s = 1'b1;
    step(1);  chk("reentry_busy", 32'(d_busy[0]), 32'h1);
              chk("blink_seed", 32'(d_led[0]), 32'h00);

    // blink with a 10-cycle hold mid-interval
    step(4);  chk("blink_s1", 32'(d_led[0]), 32'hFF);
              chk("blink_s1_tick", 32'(d_tick[0]), 32'h1);
    step(2);  hold_s = 1'b1;
    step(10); chk("hold_frozen", 32'(d_led[0]), 32'hFF);
              chk("hold_busy", 32'(d_busy[0]), 32'h1);
    hold_s = 1'b0;
    step(1);  chk("iv13_notick", 32'(d_tick[0]), 32'h0);
              chk("iv13_led", 32'(d_led[0]), 32'hFF);
    step(1);  chk("iv14_tick", 32'(d_tick[0]), 32'h1);
              chk("iv14_led", 32'(d_led[0]), 32'h00);
    step(3);  hold_s = 1'b1;
    step(1);  chk("hold_wins_tick", 32'(d_tick[0]), 32'h0);
              chk("hold_wins_led", 32'(d_led[0]), 32'h00);
    hold_s = 1'b0;
    step(1);  chk("release_step", 32'(d_tick[0]), 32'h1);
              chk("release_led", 32'(d_led[0]), 32'hFF);

    // binary count on the DIV=2 instance
    run_s = 1'b0;
    step(1);  mode_s = 2'd2; run_s = 1'b1;
    step(1);  chk("cnt_seed", 32'(d_led[2]), 32'h00);
    step(512); chk("cnt_wrap", 32'(d_led[2]), 32'h00);
               chk("cnt_wrap_tick", 32'(d_tick[2]), 32'h1);
    step(2);  chk("cnt_after_wrap", 32'(d_led[2]), 32'h01);
              chk("div1_tick_high", 32'(d_tick[1]), 32'h1);

    // asynchronous reset mid-interval in chase
    run_s = 1'b0;
    step(1);  mode_s = 2'd0; run_s = 1'b1;
    step(2);  chk("pre_rst_led", 32'(d_led[0]), 32'h01);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_led", 32'(d_led[0]), 32'h00);
    chk("arst_busy", 32'(d_busy[0]), 32'h0);
    chk("arst_div1_tick", 32'(d_tick[1]), 32'h0);
    chk("arst_div1_led", 32'(d_led[1]), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);  chk("post_rst_seed", 32'(d_led[0]), 32'h01);
              chk("post_rst_busy", 32'(d_busy[0]), 32'h1);
              chk("post_rst_tick", 32'(d_tick[0]), 32'h0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
